// File: rtl/bus_sequencer_core_pkg.sv
// Shared encodings for the bus sequencer: word field offsets, command/opcode
// encodings, compare and jump-direction selectors, FSM states, error codes.
// Latency: none (types and constants only). Backpressure: n/a.
package bus_sequencer_core_pkg;

    // Field offsets inside a sequencer word (data field width is set by the core)
    localparam int CMD_POS  = 0;
    localparam int OP_LSB   = 1;
    localparam int CFG_POS  = 4;
    localparam int DATA_LSB = 5;

    typedef enum logic {
        CMD_INSTR = 1'b0,
        CMD_XFER  = 1'b1
    } cmd_t;

    typedef enum logic [2:0] {
        OP_WAIT       = 3'd0,
        OP_COMPARE    = 3'd1,
        OP_COMP_JMP   = 3'd2,
        OP_STOP       = 3'd3,
        OP_PAUSE      = 3'd4,
        OP_UNCOND_JMP = 3'd5,
        OP_RSVD6      = 3'd6,
        OP_RSVD7      = 3'd7
    } opcode_t;

    typedef enum logic {
        CMP_NE = 1'b0,
        CMP_EQ = 1'b1
    } cmp_mode_t;

    typedef enum logic {
        JMP_DOWN = 1'b0,
        JMP_UP   = 1'b1
    } jmp_dir_t;

    typedef logic [3:0] seq_state_t;
    localparam seq_state_t ST_IDLE   = 4'd0;
    localparam seq_state_t ST_FETCH  = 4'd1;
    localparam seq_state_t ST_DECODE = 4'd2;
    localparam seq_state_t ST_XFER   = 4'd3;
    localparam seq_state_t ST_RSP    = 4'd4;
    localparam seq_state_t ST_WAIT   = 4'd5;
    localparam seq_state_t ST_PAUSE  = 4'd6;
    localparam seq_state_t ST_DONE   = 4'd7;
    localparam seq_state_t ST_ERROR  = 4'd8;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ILLEGAL = 2'd1,
        ERR_RANGE   = 2'd2,
        ERR_TIMEOUT = 2'd3
    } seq_err_t;

endpackage

// File: rtl/bus_sequencer_core_seq_cycle_timer.sv
// Loadable down-counter with optional prescaler; o_expired marks the last counted cycle.
// Latency: a load of N expires after N units (N*PRESCALE cycles with prescale on, N cycles off).
// Backpressure: none; free-runs after a load, holds at zero, a load of 0 never expires.
// Ports: i_clk, i_rst (sync, active high), i_load/i_load_val/i_pre_en load a new count,
//        o_expired is high in the final cycle of the loaded interval.
module seq_cycle_timer #(
    parameter int CNT_W    = 8,
    parameter int PRESCALE = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_pre_en,
    output logic             o_expired
);
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(PRESCALE - 1);

    logic [CNT_W-1:0] r_count;
    logic [PRE_W-1:0] r_pre;
    logic             r_pre_en;
    logic             w_tick;

    // One count unit elapses when the prescaler wraps (or every cycle when bypassed)
    assign w_tick    = !r_pre_en || (r_pre == '0);
    assign o_expired = (r_count == CNT_W'(1)) && w_tick;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count  <= '0;
            r_pre    <= '0;
            r_pre_en <= 1'b0;
        end else if (i_load) begin
            r_count  <= i_load_val;
            r_pre    <= PRE_TOP;
            r_pre_en <= i_pre_en;
        end else if (r_count != '0) begin
            if (w_tick) begin
                r_count <= r_count - CNT_W'(1);
                r_pre   <= PRE_TOP;
            end else begin
                r_pre   <= r_pre - PRE_W'(1);
            end
        end
    end
endmodule

// File: rtl/bus_sequencer_core.sv
// Program-execution engine: fetches words, issues bus transfers, runs local instructions.
// Latency: 2 cycles fetch+decode per word; transfers add handshake/response time.
// Backpressure: xfer_valid/payload held until xfer_ready; bounded by TIMEOUT (0 = unbounded).
// Ports: i_start/i_start_addr/i_resume/i_abort control; o_prog_* / i_prog_rdata program RAM;
//        o_xfer_* / i_xfer_ready and i_rsp_* protocol engine; status o_busy..o_pc.
module bus_sequencer_core
    import bus_sequencer_core_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int ADDR_W        = 8,
    parameter int WR_BIT_POS    = 2,
    parameter int WAIT_PRESCALE = 1,
    parameter int TIMEOUT       = 1024,
    localparam int WORD_W       = DATA_W + 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_start_addr,
    input  logic              i_resume,
    input  logic              i_abort,
    output logic              o_prog_rd,
    output logic [ADDR_W-1:0] o_prog_addr,
    input  logic [WORD_W-1:0] i_prog_rdata,
    output logic              o_xfer_valid,
    input  logic              i_xfer_ready,
    output logic [3:0]        o_xfer_cfg,
    output logic [DATA_W-1:0] o_xfer_data,
    input  logic              i_rsp_valid,
    input  logic [DATA_W-1:0] i_rsp_data,
    output logic              o_busy,
    output logic              o_paused,
    output logic              o_done,
    output logic              o_error,
    output logic [1:0]        o_error_code,
    output logic              o_cmp_flag,
    output logic [ADDR_W-1:0] o_pc
);
    localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int CNT_W = (DATA_W > TO_W) ? DATA_W : TO_W;
    // Jump arithmetic is wide enough that neither operand nor the sum can wrap
    localparam int JW    = ((DATA_W > ADDR_W) ? DATA_W : ADDR_W) + 1;
    localparam logic [JW-1:0] PC_MAX = {{(JW-ADDR_W){1'b0}}, {ADDR_W{1'b1}}};

    seq_state_t        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt;
    seq_err_t          r_err, w_err_nxt;
    logic              r_cmp_flag, w_cmp_nxt;
    logic [DATA_W-1:0] r_last_rdata, w_rdata_nxt;
    logic [3:0]        r_xfer_cfg;
    logic [DATA_W-1:0] r_xfer_data;

    logic              w_cmd, w_icfg, w_busy, w_adv, w_jump, w_xfer_ld, w_timeout;
    logic [3:0]        w_cfg;
    logic [2:0]        w_op;
    logic [DATA_W-1:0] w_data;
    logic [JW-1:0]     w_tgt_w;
    logic              w_jmp_bad;
    logic              w_tmr_load, w_tmr_pre, w_tmr_exp;
    logic [CNT_W-1:0]  w_tmr_val;

    assign w_cmd  = i_prog_rdata[CMD_POS];
    assign w_cfg  = i_prog_rdata[CFG_POS:OP_LSB];
    assign w_op   = i_prog_rdata[OP_LSB+2:OP_LSB];
    assign w_icfg = i_prog_rdata[CFG_POS];
    assign w_data = i_prog_rdata[DATA_LSB+DATA_W-1:DATA_LSB];

    // An upward jump past address 0 borrows and lands above PC_MAX, so one
    // range compare covers both directions.
    assign w_tgt_w   = (w_icfg == JMP_UP) ? (JW'(r_pc) - JW'(w_data)) : (JW'(r_pc) + JW'(w_data));
    assign w_jmp_bad = (w_data == '0) || (w_tgt_w > PC_MAX);

    assign w_busy    = !((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERROR));
    assign w_timeout = (TIMEOUT != 0) && w_tmr_exp;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_err_nxt   = r_err;
        w_cmp_nxt   = r_cmp_flag;
        w_rdata_nxt = r_last_rdata;
        w_adv       = 1'b0;
        w_jump      = 1'b0;
        w_xfer_ld   = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;
        w_tmr_pre   = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (i_start) begin
                    w_state_nxt = ST_FETCH;
                    w_pc_nxt    = i_start_addr;
                    w_err_nxt   = ERR_NONE;
                end
            end
            ST_FETCH: w_state_nxt = ST_DECODE;
            ST_DECODE: begin
                if (w_cmd == CMD_XFER) begin
                    w_state_nxt = ST_XFER;
                    w_xfer_ld   = 1'b1;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = CNT_W'(TIMEOUT);
                end else begin
                    unique case (opcode_t'(w_op))
                        OP_WAIT: begin
                            if (w_data == '0) begin
                                w_adv = 1'b1;
                            end else begin
                                w_state_nxt = ST_WAIT;
                                w_tmr_load  = 1'b1;
                                w_tmr_val   = CNT_W'(w_data);
                                w_tmr_pre   = 1'b1;
                            end
                        end
                        OP_COMPARE: begin
                            w_cmp_nxt = (w_icfg == CMP_EQ) ? (r_last_rdata == w_data)
                                                           : (r_last_rdata != w_data);
                            w_adv     = 1'b1;
                        end
                        OP_COMP_JMP: begin
                            w_jump = r_cmp_flag;
                            w_adv  = !r_cmp_flag;
                        end
                        OP_UNCOND_JMP: w_jump = 1'b1;
                        OP_STOP:       w_state_nxt = ST_DONE;
                        OP_PAUSE:      w_state_nxt = ST_PAUSE;
                        default: begin
                            w_state_nxt = ST_ERROR;
                            w_err_nxt   = ERR_ILLEGAL;
                        end
                    endcase
                end
            end
            ST_XFER: begin
                if (i_xfer_ready) begin
                    if (r_xfer_cfg[WR_BIT_POS]) begin
                        w_adv = 1'b1;
                    end else begin
                        w_state_nxt = ST_RSP;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = CNT_W'(TIMEOUT);
                    end
                end else if (w_timeout) begin
                    w_state_nxt = ST_ERROR;
                    w_err_nxt   = ERR_TIMEOUT;
                end
            end
            ST_RSP: begin
                if (i_rsp_valid) begin
                    w_rdata_nxt = i_rsp_data;
                    w_adv       = 1'b1;
                end else if (w_timeout) begin
                    w_state_nxt = ST_ERROR;
                    w_err_nxt   = ERR_TIMEOUT;
                end
            end
            ST_WAIT:  w_adv = w_tmr_exp;
            ST_PAUSE: w_adv = i_resume;
            default:  w_state_nxt = ST_IDLE;
        endcase

        // pc is left on the faulting word when a jump or increment is out of range
        if (w_jump) begin
            if (w_jmp_bad) begin
                w_state_nxt = ST_ERROR;
                w_err_nxt   = ERR_RANGE;
            end else begin
                w_state_nxt = ST_FETCH;
                w_pc_nxt    = w_tgt_w[ADDR_W-1:0];
            end
        end
        if (w_adv) begin
            if (&r_pc) begin
                w_state_nxt = ST_ERROR;
                w_err_nxt   = ERR_RANGE;
            end else begin
                w_state_nxt = ST_FETCH;
                w_pc_nxt    = r_pc + ADDR_W'(1);
            end
        end

        // Abort beats everything, including a same-cycle start; flags are frozen
        if (i_abort && w_busy) begin
            w_state_nxt = ST_IDLE;
            w_pc_nxt    = r_pc;
            w_err_nxt   = r_err;
            w_cmp_nxt   = r_cmp_flag;
            w_rdata_nxt = r_last_rdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_pc         <= '0;
            r_err        <= ERR_NONE;
            r_cmp_flag   <= 1'b0;
            r_last_rdata <= '0;
            r_xfer_cfg   <= '0;
            r_xfer_data  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_err        <= w_err_nxt;
            r_cmp_flag   <= w_cmp_nxt;
            r_last_rdata <= w_rdata_nxt;
            if (w_xfer_ld) begin
                r_xfer_cfg  <= w_cfg;
                r_xfer_data <= w_data;
            end
        end
    end

    seq_cycle_timer #(
        .CNT_W    (CNT_W),
        .PRESCALE (WAIT_PRESCALE)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_pre_en   (w_tmr_pre),
        .o_expired  (w_tmr_exp)
    );

    assign o_prog_rd    = (r_state == ST_FETCH);
    assign o_prog_addr  = r_pc;
    assign o_xfer_valid = (r_state == ST_XFER);
    assign o_xfer_cfg   = r_xfer_cfg;
    assign o_xfer_data  = r_xfer_data;
    assign o_busy       = w_busy;
    assign o_paused     = (r_state == ST_PAUSE);
    assign o_done       = (r_state == ST_DONE);
    assign o_error      = (r_state == ST_ERROR);
    assign o_error_code = r_err;
    assign o_cmp_flag   = r_cmp_flag;
    assign o_pc         = r_pc;
endmodule

// File: tb/tb_bus_sequencer_core.sv
// Directed bench for bus_sequencer_core with a program-RAM model and a transfer scoreboard.
// Latency: n/a. Backpressure: the bench plays the protocol engine and stalls xfer_ready.
module tb_bus_sequencer_core;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int WORD_W = DATA_W + 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_start = 1'b0, i_resume = 1'b0, i_abort = 1'b0;
    logic [ADDR_W-1:0] i_start_addr = '0;
    logic              o_prog_rd;
    logic [ADDR_W-1:0] o_prog_addr;
    logic [WORD_W-1:0] i_prog_rdata = '0;
    logic              o_xfer_valid;
    logic              i_xfer_ready = 1'b0;
    logic [3:0]        o_xfer_cfg;
    logic [DATA_W-1:0] o_xfer_data;
    logic              i_rsp_valid = 1'b0;
    logic [DATA_W-1:0] i_rsp_data = '0;
    logic              o_busy, o_paused, o_done, o_error, o_cmp_flag;
    logic [1:0]        o_error_code;
    logic [ADDR_W-1:0] o_pc;

    logic [WORD_W-1:0] mem [0:255];
    logic [11:0]       sb [$];      // expected {cfg, data} per transfer
    int                n_checks = 0;
    int                n_errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (o_prog_rd) i_prog_rdata <= mem[o_prog_addr];

    bus_sequencer_core #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WR_BIT_POS(2), .WAIT_PRESCALE(4), .TIMEOUT(16)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_start_addr(i_start_addr),
        .i_resume(i_resume), .i_abort(i_abort), .o_prog_rd(o_prog_rd), .o_prog_addr(o_prog_addr),
        .i_prog_rdata(i_prog_rdata), .o_xfer_valid(o_xfer_valid), .i_xfer_ready(i_xfer_ready),
        .o_xfer_cfg(o_xfer_cfg), .o_xfer_data(o_xfer_data), .i_rsp_valid(i_rsp_valid),
        .i_rsp_data(i_rsp_data), .o_busy(o_busy), .o_paused(o_paused), .o_done(o_done),
        .o_error(o_error), .o_error_code(o_error_code), .o_cmp_flag(o_cmp_flag), .o_pc(o_pc)
    );

    function automatic logic [WORD_W-1:0] xw(input logic [3:0] cfg, input logic [7:0] d);
        return {d, cfg, 1'b1};
    endfunction

    function automatic logic [WORD_W-1:0] iw(input logic [2:0] op, input logic icfg, input logic [7:0] d);
        return {d, icfg, op, 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_at(input logic [7:0] a);
        i_start_addr = a;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_not_busy(input string tag);
        int n = 0;
        while (o_busy && n < 200) begin tick(); n++; end
        chk({tag, "_settled"}, o_busy, 0);
    endtask

    // Wait for a request, then check it against the scoreboard head
    task automatic take_head(input string tag, input logic [7:0] exp_pc, output logic [11:0] e);
        int n = 0;
        while (!o_xfer_valid && n < 100) begin tick(); n++; end
        chk({tag, "_seen"}, o_xfer_valid, 1);
        e = (sb.size() != 0) ? sb.pop_front() : 12'hFFF;
        chk({tag, "_pc"}, o_pc, exp_pc);
        chk({tag, "_cfg"}, o_xfer_cfg, e[11:8]);
        chk({tag, "_data"}, o_xfer_data, e[7:0]);
    endtask

    task automatic service_xfer(input string tag, input int hold, input logic [7:0] rsp,
                                input logic [7:0] exp_pc);
        logic [11:0] e;
        take_head(tag, exp_pc, e);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold_vld"}, o_xfer_valid, 1);
            chk({tag, "_hold_cfg"}, o_xfer_cfg, e[11:8]);
            chk({tag, "_hold_data"}, o_xfer_data, e[7:0]);
        end
        i_xfer_ready = 1'b1;
        tick();
        i_xfer_ready = 1'b0;
        if (!e[10]) begin
            i_rsp_valid = 1'b1;
            i_rsp_data  = rsp;
            tick();
            i_rsp_valid = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [11:0] e;
        for (int i = 0; i < 256; i++) mem[i] = iw(3'd6, 1'b0, 8'h00);
        mem[8'h00] = xw(4'b0101, 8'hA0);    mem[8'h01] = iw(3'd3, 1'b0, 8'h00);
        mem[8'h02] = iw(3'd5, 1'b1, 8'h05);
        mem[8'h10] = xw(4'b0001, 8'h55);    mem[8'h11] = iw(3'd1, 1'b1, 8'h3C);
        mem[8'h12] = iw(3'd2, 1'b1, 8'h02); mem[8'h13] = iw(3'd3, 1'b0, 8'h00);
        mem[8'h20] = iw(3'd0, 1'b0, 8'h05); mem[8'h21] = iw(3'd0, 1'b0, 8'h00);
        mem[8'h22] = iw(3'd3, 1'b0, 8'h00);
        mem[8'h30] = iw(3'd4, 1'b0, 8'h00); mem[8'h31] = iw(3'd3, 1'b0, 8'h00);
        mem[8'h50] = xw(4'b0100, 8'h77);
        mem[8'h60] = iw(3'd1, 1'b0, 8'hFF); mem[8'h61] = xw(4'b0100, 8'h99);
        mem[8'hFF] = iw(3'd1, 1'b1, 8'h00);

        // Reset
        repeat (3) tick();
        chk("rst_busy", o_busy, 0);        chk("rst_done", o_done, 0);
        chk("rst_error", o_error, 0);      chk("rst_code", o_error_code, 0);
        chk("rst_xvld", o_xfer_valid, 0);  chk("rst_prog_rd", o_prog_rd, 0);
        chk("rst_pc", o_pc, 0);            chk("rst_cmp", o_cmp_flag, 0);
        chk("rst_paused", o_paused, 0);    chk("rst_xcfg", o_xfer_cfg, 0);
        rst = 1'b0;
        tick();

        // Abort while idle does nothing
        i_abort = 1'b1; tick(); i_abort = 1'b0;
        chk("idle_abort_busy", o_busy, 0);

        // 1: write transfer with stalled ready, then STOP
        sb.push_back({4'b0101, 8'hA0});
        start_at(8'h00);
        chk("t1_fetch_rd", o_prog_rd, 1);
        service_xfer("t1", 3, 8'h00, 8'h00);
        wait_not_busy("t1");
        chk("t1_done", o_done, 1);
        chk("t1_pc", o_pc, 8'h01);

        // 2: read, compare, conditional jump back; second pass falls through
        sb.push_back({4'b0001, 8'h55});
        sb.push_back({4'b0001, 8'h55});
        start_at(8'h10);
        service_xfer("t2a", 0, 8'h3C, 8'h10);
        service_xfer("t2b", 1, 8'h3D, 8'h10);
        chk("t2_cmp_after_jump", o_cmp_flag, 1);
        wait_not_busy("t2");
        chk("t2_done", o_done, 1);
        chk("t2_pc", o_pc, 8'h13);
        chk("t2_cmp_final", o_cmp_flag, 0);

        // 3: WAIT 5 units of 4 cycles, then WAIT 0
        start_at(8'h20);
        n = 0;
        do begin tick(); n++; end while (!o_prog_rd && n < 100);
        chk("t3_wait5_cycles", n, 22);
        chk("t3_wait5_addr", o_prog_addr, 8'h21);
        n = 0;
        do begin tick(); n++; end while (!o_prog_rd && n < 100);
        chk("t3_wait0_cycles", n, 2);
        chk("t3_wait0_addr", o_prog_addr, 8'h22);
        wait_not_busy("t3");
        chk("t3_done", o_done, 1);

        // 4: PAUSE, early resume ignored, start while busy ignored
        start_at(8'h30);
        i_resume = 1'b1; tick(); i_resume = 1'b0;
        tick();
        chk("t4_paused", o_paused, 1);
        chk("t4_busy", o_busy, 1);
        i_start_addr = 8'h00; i_start = 1'b1; tick(); i_start = 1'b0;
        repeat (4) tick();
        chk("t4_still_paused", o_paused, 1);
        chk("t4_pc_held", o_pc, 8'h30);
        i_resume = 1'b1; tick(); i_resume = 1'b0;
        chk("t4_unpaused", o_paused, 0);
        chk("t4_pc_adv", o_pc, 8'h31);
        wait_not_busy("t4");
        chk("t4_done", o_done, 1);

        // 5: error cases
        start_at(8'h40);
        wait_not_busy("t5a");
        chk("t5a_error", o_error, 1);
        chk("t5a_code", o_error_code, 1);
        chk("t5a_pc", o_pc, 8'h40);

        start_at(8'h02);
        chk("t5b_cleared", o_error, 0);
        chk("t5b_code_cleared", o_error_code, 0);
        wait_not_busy("t5b");
        chk("t5b_code", o_error_code, 2);
        chk("t5b_pc", o_pc, 8'h02);

        start_at(8'hFF);
        wait_not_busy("t5c");
        chk("t5c_code", o_error_code, 2);
        chk("t5c_pc", o_pc, 8'hFF);

        sb.push_back({4'b0100, 8'h77});
        start_at(8'h50);
        take_head("t5d", 8'h50, e);
        n = 0;
        while (o_xfer_valid && n < 100) begin tick(); n++; end
        chk("t5d_xfer_cycles", n, 16);
        chk("t5d_error", o_error, 1);
        chk("t5d_code", o_error_code, 3);
        chk("t5d_xvld", o_xfer_valid, 0);

        start_at(8'h01);
        chk("t5e_error_clr", o_error, 0);
        chk("t5e_code_clr", o_error_code, 0);
        wait_not_busy("t5e");
        chk("t5e_done", o_done, 1);

        // 6: abort mid-transfer with a same-cycle start
        sb.push_back({4'b0100, 8'h99});
        start_at(8'h60);
        take_head("t6", 8'h61, e);
        chk("t6_cmp", o_cmp_flag, 1);
        repeat (2) tick();
        i_abort = 1'b1; i_start = 1'b1; i_start_addr = 8'h60;
        tick();
        i_abort = 1'b0; i_start = 1'b0;
        chk("t6_xvld", o_xfer_valid, 0);
        chk("t6_busy", o_busy, 0);
        chk("t6_cmp_kept", o_cmp_flag, 1);
        repeat (3) tick();
        chk("t6_no_restart_busy", o_busy, 0);
        chk("t6_no_restart_rd", o_prog_rd, 0);

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/bus_sequencer_core.md
Name: bus_sequencer_core

Overview:
Parametrised program-execution engine for the FPGA bus sequencer. It fetches sequencer words from an external program RAM and decodes each one as either a bus transfer or an instruction. Transfers go to a protocol engine (I2C or SPI) over a valid/ready handshake. Instructions (wait, compare, conditional/unconditional jump, pause, stop) are executed locally. Compared with the fixed 8-bit word format, this core adds a generic data width, a configurable write-bit position, a transfer timeout and error reporting.

Parameters:
DATA_W, 8, data field width; word width WORD_W = DATA_W+5
ADDR_W, 8, program address width; program depth is 2**ADDR_W
WR_BIT_POS, 2, index of the write bit within the 4-bit transfer config (2 = I2C, 0 = SPI)
WAIT_PRESCALE, 1, clock cycles per WAIT count unit (≥1)
TIMEOUT, 1024, maximum cycles to wait for xfer_ready or rsp_valid; 0 disables the timeout

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  pulse: begin execution at start_addr
start_addr  in  ADDR_W  first program address
resume  in  1  pulse: leave PAUSE
abort  in  1  pulse: return to IDLE from any state
prog_rd  out  1  program RAM read enable
prog_addr  out  ADDR_W  program RAM address
prog_rdata  in  WORD_W  program word, valid 1 cycle after prog_rd
xfer_valid  out  1  transfer request
xfer_ready  in  1  engine accepts request
xfer_cfg  out  4  transfer config field
xfer_data  out  DATA_W  transfer data field
rsp_valid  in  1  read data returned by engine
rsp_data  in  DATA_W  read data
busy  out  1  high in any state except IDLE, DONE and ERROR
paused  out  1  high in PAUSE
done  out  1  high in DONE, after STOP
error  out  1  high in ERROR
error_code  out  2  1 = illegal opcode, 2 = PC out of range, 3 = timeout
cmp_flag  out  1  result of the last COMPARE
pc  out  ADDR_W  current program counter

Behaviour:
- Reset: state IDLE; all outputs 0; pc = 0; last_rdata = 0.
- Word fields:
  - bit0 = cmd (1 = transfer, 0 = instruction).
  - Transfer: cfg = [4:1], data = [DATA_W+4:5].
  - Instruction: opcode = [3:1], icfg = [4], data = [DATA_W+4:5].
- States: IDLE, FETCH, DECODE, XFER, RSP, WAIT, PAUSE, DONE, ERROR.
- IDLE/DONE/ERROR + start → FETCH with pc = start_addr. Entering FETCH clears done, error and error_code.
- FETCH: prog_rd = 1, prog_addr = pc, for one cycle → DECODE. prog_rdata is sampled in DECODE.
- DECODE, transfer word: drive xfer_cfg/xfer_data and set xfer_valid → XFER.
- XFER:
  - xfer_valid and payload are held stable until xfer_ready is high.
  - On the handshake, go to RSP if cfg[WR_BIT_POS] = 0 (read); otherwise pc+1 → FETCH.
  - xfer_ready is ignored outside XFER.
- RSP: on rsp_valid, last_rdata = rsp_data, pc+1 → FETCH. rsp_valid is ignored outside RSP.
- Timeout: counts cycles in XFER or RSP. Reaching TIMEOUT → ERROR with code 3; xfer_valid drops.
- Opcode 0, WAIT: wait data*WAIT_PRESCALE cycles in WAIT, then pc+1 → FETCH. data = 0 goes straight to FETCH.
- Opcode 1, COMPARE:
  - icfg = 1: cmp_flag = (last_rdata == data).
  - icfg = 0: cmp_flag = (last_rdata != data).
  - Then pc+1 → FETCH.
- Opcode 2, COMP_JMP: if cmp_flag, jump; otherwise pc+1.
- Opcode 5, UNCOND_JMP: always jump.
- Jump target: icfg = 1 (up) → pc − data; icfg = 0 (down) → pc + data, using unsigned ADDR_W+1 arithmetic.
- Jump/PC errors → ERROR with code 2:
  - target below 0 or above 2**ADDR_W−1;
  - offset 0;
  - pc+1 overflowing past the last address.
- Opcode 3, STOP → DONE (done = 1, busy = 0).
- Opcode 4, PAUSE: enter PAUSE (paused = 1). resume → pc+1, FETCH. resume outside PAUSE is ignored.
- Opcodes 6 and 7 → ERROR with code 1.
- Ignored events: start while busy; abort while not busy.
- abort while busy: next cycle IDLE; xfer_valid and prog_rd drop (the engine must also be flushed); cmp_flag is kept.
- Same-cycle start and abort: abort wins.
- pc is held at the faulting address in ERROR.

Decomposition:
- Package additions: cmd/opcode enums (existing encodings), compare/jump-direction enums, seq_state_t, seq_err_t (NONE=0, ILLEGAL=1, RANGE=2, TIMEOUT=3), field offset localparams CMD_POS=0, OP_LSB=1, CFG_POS=4, DATA_LSB=5.
- DATA_W-dependent slicing stays in the module.
- One sub-module, seq_cycle_timer: a loadable down-counter with prescaler and an expired flag, shared by WAIT and the timeout.

Test Plan:
1. Transfer chain, defaults. Program at 0: write transfer cfg = 4'b0101, data = 8'hA0; then STOP. start → one xfer_valid with cfg = 5, data = A0. Hold xfer_ready low for 3 cycles, payload stays stable. Then done = 1, pc = 1.
2. Read and compare. Read transfer (cfg[2] = 0); engine returns rsp_data = 8'h3C; COMPARE icfg = 1, data = 3C; COMP_JMP up by 2 → cmp_flag = 1 and pc returns to the read transfer. A second run with rsp_data = 8'h3D falls through to STOP.
3. WAIT with data = 5, WAIT_PRESCALE = 4 → exactly 20 cycles between DECODE and the next FETCH. data = 0 adds no WAIT cycles.
4. PAUSE: paused = 1 and busy = 1 until resume; a resume pulsed earlier is ignored; after resume, pc advances by 1.
5. Errors:
   - opcode 6 → error_code = 1;
   - UNCOND_JMP up by 5 at pc = 2 → error_code = 2;
   - xfer_ready stuck low with TIMEOUT = 16 → error_code = 3 after 16 cycles in XFER, xfer_valid = 0;
   - a new start clears the error.
6. abort mid-XFER together with start in the same cycle → IDLE next cycle, xfer_valid = 0, busy = 0, no restart.
